spi_slave_fifo: RTL and testbench

//  Parametrised SPI slave with configurable word width, bit order and RX/TX FIFOs.

---
 rtl/spi_slave_fifo.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_slave_fifo.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_fifo.sv
// Purpose: SPI slave (modes 0-3, DATA_WIDTH-bit words, MSB/LSB first) with RX/TX FIFOs toward the local host.
// Latency: rx_empty falls 2 sysclk cycles after the synchronised final sample edge of a word.
// Backpressure: tx_we is ignored while tx_full; a full RX FIFO drops the word and sets rx_overflow.
//
// Optional feature macro: SPI_SLAVE_FRAME_IRQ_EN adds the frame_done output.
//
// Ports:
//   sysclk, reset       system clock, synchronous active-high reset
//   enable              0 holds the internal slave-select view high (idle)
//   sck, mosi, ss       asynchronous SPI pins, each double-flopped into sysclk
//   miso                current outgoing bit (shift reg MSB, or LSB when lsb_first)
//   cpol, cpha          SPI mode, change only while ss is high
//   lsb_first           bit order, latched while the engine is idle
//   tx_data/tx_we       host push into TX FIFO; tx_full/tx_empty status
//   rx_data/rx_re       first-word-fall-through head of RX FIFO and pop; rx_empty status
//   rx_overflow         sticky: received word dropped on a full RX FIFO
//   tx_underflow        sticky: TX_FILL shifted out because TX FIFO was empty
//   clear_error         clears both sticky flags, wins over a same-cycle set
//   frame_done          (macro only) 1-cycle pulse when a frame ends

// Small synchronous FIFO, first-word-fall-through head; reads as zero when empty.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: push on full succeeds only together with a pop; pop on empty is ignored.
module spi_slave_fifo_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop_rdy && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_vld && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  assign head_dat = empty ? '0 : mem[rd_ptr];
endmodule

module spi_slave_fifo #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [DATA_WIDTH-1:0] TX_FILL    = '0
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sck,
  input  logic                  mosi,
  input  logic                  ss,
  output logic                  miso,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_we,
  output logic                  tx_full,
  output logic                  tx_empty,
  output logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_re,
  output logic                  rx_empty,
  output logic                  rx_overflow,
  output logic                  tx_underflow,
  input  logic                  clear_error
`ifdef SPI_SLAVE_FRAME_IRQ_EN
  ,
  output logic                  frame_done
`endif
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    sck_sync;
  logic [1:0]    mosi_sync;
  logic [1:0]    ss_sync;
  logic          nsck;
  logic          nsck_d;
  logic          ss_int;
  logic          ss_d;
  logic          sample_edge;
  logic          ss_fall;
  logic          lsb_q;
  logic [DW-1:0] sr;
  logic [DW-1:0] sr_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          done;
  logic          done_nxt;
  logic          load;
  logic          tx_pop;
  logic [DW-1:0] tx_head;
  logic          rx_push;
  logic          rx_full;
  logic          ovf_set;
  logic          unf_set;

  // Pin synchronisers. ss history resets low so that a slave select already
  // low across reset is not mistaken for a new falling edge: shifting resumes
  // only on the next genuine ss assertion.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      nsck_d    <= 1'b0;
      ss_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      ss_sync   <= {ss_sync[0], ss};
      nsck_d    <= nsck;
      ss_d      <= ss_int;
    end
  end

  // Normalising by cpol^cpha makes the sample edge a rising nsck in all four
  // modes. Only the sample edge is used: the outgoing bit advances together
  // with the capture, a few sysclk after the master has already sampled it.
  assign nsck        = sck_sync[1] ^ (cpol ^ cpha);
  assign ss_int      = enable ? ss_sync[1] : 1'b1;
  assign sample_edge = nsck && !nsck_d;
  assign ss_fall     = ss_d && !ss_int;

  // FSM state and datapath registers.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      done  <= 1'b0;
      lsb_q <= 1'b0;
    end else begin
      state <= state_nxt;
      sr    <= sr_nxt;
      cnt   <= cnt_nxt;
      done  <= done_nxt;
      if (state == IDLE) lsb_q <= lsb_first;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (ss_fall) state_nxt = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        // Level test, so a deassertion during LOAD is still seen here.
        if (ss_int) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (done) begin
          // The completed word leaves via rx_push this cycle; refill from TX.
          load    = 1'b1;
          cnt_nxt = '0;
        end else if (sample_edge) begin
          sr_nxt = lsb_q ? {mosi_sync[1], sr[DW-1:1]} : {sr[DW-2:0], mosi_sync[1]};
          if (cnt == CW'(DW-1)) begin
            done_nxt = 1'b1;
            cnt_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (load) sr_nxt = tx_empty ? TX_FILL : tx_head;
  end

  assign miso    = lsb_q ? sr[0] : sr[DW-1];
  assign tx_pop  = load && !tx_empty;
  assign unf_set = load && tx_empty;
  // Pushed even if ss rose in the same cycle: the word was already complete.
  assign rx_push = done;
  // A same-cycle host pop makes room, so the push is not a drop.
  assign ovf_set = rx_push && rx_full && !rx_re;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else if (clear_error) begin
      rx_overflow  <= 1'b0;
      tx_underflow <= 1'b0;
    end else begin
      if (ovf_set) rx_overflow  <= 1'b1;
      if (unf_set) tx_underflow <= 1'b1;
    end
  end

`ifdef SPI_SLAVE_FRAME_IRQ_EN
  always_ff @(posedge sysclk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= (state == SHIFT) && (state_nxt == IDLE);
  end
`endif

  spi_slave_fifo_buf #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk      (sysclk),
    .reset    (reset),
    .push_vld (tx_we),
    .push_dat (tx_data),
    .pop_rdy  (tx_pop),
    .head_dat (tx_head),
    .full     (tx_full),
    .empty    (tx_empty)
  );

  spi_slave_fifo_buf #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk      (sysclk),
    .reset    (reset),
    .push_vld (rx_push),
    .push_dat (sr),
    .pop_rdy  (rx_re),
    .head_dat (rx_data),
    .full     (rx_full),
    .empty    (rx_empty)
  );
endmodule

// File: tb/tb_spi_slave_fifo.sv
// Bench for spi_slave_fifo: behavioural SPI master plus queue scoreboard.
// Expected master-read words and expected RX words are queued when a transfer is set up.
// They are popped and compared when the master finishes a word or the host pops RX.
module tb_spi_slave_fifo;
  localparam int HALF = 50;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       enable;
  logic       sck;
  logic       mosi;
  logic       ss;
  logic       miso;
  logic       cpol;
  logic       cpha;
  logic       lsb_first;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_full;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_re;
  logic       rx_empty;
  logic       rx_overflow;
  logic       tx_underflow;
  logic       clear_error;
`ifdef SPI_SLAVE_FRAME_IRQ_EN
  logic       frame_done;
  int         fd_cnt = 0;
  int         fd_base;
  always @(posedge sysclk) if (frame_done) fd_cnt <= fd_cnt + 1;
`endif

  always #5 sysclk = ~sysclk;

  spi_slave_fifo #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (4),
    .TX_FILL    (8'hFF)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .enable       (enable),
    .sck          (sck),
    .mosi         (mosi),
    .ss           (ss),
    .miso         (miso),
    .cpol         (cpol),
    .cpha         (cpha),
    .lsb_first    (lsb_first),
    .tx_data      (tx_data),
    .tx_we        (tx_we),
    .tx_full      (tx_full),
    .tx_empty     (tx_empty),
    .rx_data      (rx_data),
    .rx_re        (rx_re),
    .rx_empty     (rx_empty),
    .rx_overflow  (rx_overflow),
    .tx_underflow (tx_underflow),
    .clear_error  (clear_error)
`ifdef SPI_SLAVE_FRAME_IRQ_EN
    ,
    .frame_done   (frame_done)
`endif
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] miso_q[$];
  logic [7:0] rx_q[$];

  task automatic check_dat(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tx_push(input logic [7:0] w);
    @(negedge sysclk);
    tx_data = w;
    tx_we   = 1'b1;
    @(negedge sysclk);
    tx_we   = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge sysclk);
    clear_error = 1'b1;
    @(negedge sysclk);
    clear_error = 1'b0;
  endtask

  // All SPI timing is in multiples of the sysclk period starting on a
  // falling sysclk edge, so miso is always sampled away from the active edge.
  task automatic frame_begin(input logic pol, input logic pha);
    @(negedge sysclk);
    cpol = pol;
    cpha = pha;
    sck  = pol;
    #100;
    ss   = 1'b0;
    #100;
  endtask

  task automatic frame_end();
    #100;
    ss = 1'b1;
    #200;
  endtask

  // Master side, always MSB first on the wire.
  task automatic spi_word(input logic [7:0] w, input int nbits, output logic [7:0] r);
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = w[7-i];
        #HALF;
        r    = {r[6:0], miso};
        sck  = ~cpol;
        #HALF;
        sck  = cpol;
      end else begin
        sck  = ~cpol;
        mosi = w[7-i];
        #HALF;
        r    = {r[6:0], miso};
        sck  = cpol;
        #HALF;
      end
    end
  endtask

  task automatic master_word(input string tag, input logic [7:0] w);
    logic [7:0] r;
    spi_word(w, 8, r);
    if (miso_q.size() > 0) check_dat(tag, r, miso_q.pop_front());
    else check_dat({tag, "_unexpected"}, r, 8'h00);
  endtask

  task automatic rx_pop_check(input string tag);
    check_dat({tag, "_rx_empty"}, rx_empty, 1'b0);
    if (rx_q.size() > 0) check_dat(tag, rx_data, rx_q.pop_front());
    @(negedge sysclk);
    rx_re = 1'b1;
    @(negedge sysclk);
    rx_re = 1'b0;
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] r;
    reset = 1'b1; enable = 1'b1; sck = 1'b0; mosi = 1'b0; ss = 1'b1;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; tx_data = '0; tx_we = 1'b0;
    rx_re = 1'b0; clear_error = 1'b0;
    repeat (4) @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);

    check_dat("rst_miso", miso, 1'b0);
    check_dat("rst_rx_data", rx_data, 8'h00);
    check_dat("rst_rx_empty", rx_empty, 1'b1);
    check_dat("rst_tx_empty", tx_empty, 1'b1);
    check_dat("rst_tx_full", tx_full, 1'b0);
    check_dat("rst_rx_overflow", rx_overflow, 1'b0);
    check_dat("rst_tx_underflow", tx_underflow, 1'b0);

    // All four modes: slave sends 0xA5, master sends 0x3C.
    for (int m = 0; m < 4; m++) begin
      logic pol;
      logic pha;
      pol = m[1];
      pha = m[0];
      tx_push(8'hA5);
      miso_q.push_back(8'hA5);
      rx_q.push_back(8'h3C);
      frame_begin(pol, pha);
      master_word($sformatf("mode%0d_miso", m), 8'h3C);
      frame_end();
      rx_pop_check($sformatf("mode%0d_rx", m));
    end

    // LSB first on the slave side.
    lsb_first = 1'b1;
    tx_push(8'h01);
    miso_q.push_back(8'h80);
    rx_q.push_back(8'h01);
    frame_begin(1'b0, 1'b0);
    master_word("lsb_miso", 8'h80);
    frame_end();
    rx_pop_check("lsb_rx");
    lsb_first = 1'b0;

    // Full TX FIFO, five back-to-back words into a four-deep RX FIFO.
    clear_err();
    check_dat("clr_underflow", tx_underflow, 1'b0);
    tx_push(8'h11); tx_push(8'h22); tx_push(8'h33); tx_push(8'h44);
    check_dat("tx_full", tx_full, 1'b1);
    check_dat("tx_full_not_empty", tx_empty, 1'b0);
    tx_push(8'h55);  // dropped: FIFO full
    miso_q.push_back(8'h11); miso_q.push_back(8'h22); miso_q.push_back(8'h33);
    miso_q.push_back(8'h44); miso_q.push_back(8'hFF);
    for (int i = 0; i < 4; i++) rx_q.push_back(8'(8'hC1 + i));
    frame_begin(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      w = 8'(8'hC1 + i);
      master_word($sformatf("b2b_miso%0d", i), w);
    end
    frame_end();
    check_dat("ovf_flag", rx_overflow, 1'b1);
    check_dat("ovf_underflow", tx_underflow, 1'b1);
    check_dat("ovf_tx_empty", tx_empty, 1'b1);
    for (int i = 0; i < 4; i++) rx_pop_check($sformatf("ovf_rx%0d", i));
    check_dat("ovf_drained", rx_empty, 1'b1);
    check_dat("ovf_drained_data", rx_data, 8'h00);
    clear_err();
    check_dat("ovf_clr", rx_overflow, 1'b0);
    check_dat("unf_clr", tx_underflow, 1'b0);

    // Empty TX: TX_FILL goes out, underflow sets, clear_error drops it.
    check_dat("unf_tx_empty", tx_empty, 1'b1);
    miso_q.push_back(8'hFF);
    rx_q.push_back(8'h5A);
    frame_begin(1'b1, 1'b1);
    master_word("unf_miso", 8'h5A);
    frame_end();
    check_dat("unf_flag", tx_underflow, 1'b1);
    check_dat("unf_no_ovf", rx_overflow, 1'b0);
    rx_pop_check("unf_rx");
    clear_err();
    check_dat("unf_cleared", tx_underflow, 1'b0);

    // Aborted frame after 5 bits, then a full 0x55 frame.
`ifdef SPI_SLAVE_FRAME_IRQ_EN
    fd_base = fd_cnt;
`endif
    tx_push(8'h96);
    frame_begin(1'b0, 1'b0);
    spi_word(8'hF0, 5, r);
    frame_end();
    check_dat("abort_no_rx", rx_empty, 1'b1);
    check_dat("abort_tx_consumed", tx_empty, 1'b1);
    miso_q.push_back(8'hFF);
    rx_q.push_back(8'h55);
    frame_begin(1'b0, 1'b0);
    master_word("after_abort_miso", 8'h55);
    frame_end();
    rx_pop_check("after_abort_rx");
    check_dat("after_abort_empty", rx_empty, 1'b1);
`ifdef SPI_SLAVE_FRAME_IRQ_EN
    check_dat("frame_done_pulses", fd_cnt - fd_base, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
